// File: rtl/riscy_mem_pkg.sv
// Shared types and the byte-enable merge helper for the RI5CY memory responder.
package riscy_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} chan_state_e;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  be_t;

    function automatic word_t apply_be(word_t old, word_t wdata, be_t be);
        word_t res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : old[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/riscy_mem_channel.sv
// One req/gnt/rvalid slave handshake with a programmable grant latency counter.
module riscy_mem_channel
    import riscy_mem_pkg::*;
#(
    parameter int GNT_LATENCY = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic [1:0] extra_i,
    output logic       gnt_o,
    output logic       rvalid_o
);

    chan_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  lat;
    logic        gnt;

    assign lat = 5'(GNT_LATENCY) + {3'b000, extra_i};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                // RESP behaves like IDLE so a held req can be re-granted during rvalid
                if (req_i) begin
                    if (lat == 5'd0) begin
                        gnt     = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = lat - 5'd1;
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!req_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 5'd0) begin
                    gnt     = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o    = gnt & ~rst_i;
    assign rvalid_o = (state_q == RESP);

endmodule

// File: rtl/riscy_mem_responder.sv
// Shared word memory answering the RI5CY instr/data ports, with a backdoor init port.
// Define RISCY_MEM_STALL_EN to add LFSR-driven random extra grant wait cycles.
module riscy_mem_responder
    import riscy_mem_pkg::*;
#(
    parameter int    MEM_WORDS   = 1024,
    parameter int    GNT_LATENCY = 0,
    parameter word_t BOOT_WORD   = 32'h0000_0013
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    input  logic                         data_req_i,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [31:0]                  data_addr_i,
    input  logic [31:0]                  data_wdata_i,
    output logic                         data_gnt_o,
    output logic                         data_rvalid_o,
    output logic [31:0]                  data_rdata_o,
    input  logic                         init_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr_i,
    input  logic [31:0]                  init_wdata_i
);

    localparam int AW = $clog2(MEM_WORDS);

    word_t          mem_q [MEM_WORDS] = '{default: BOOT_WORD};
    word_t          instr_rdata_q, data_rdata_q;
    logic [AW-1:0]  instr_idx, data_idx;
    logic [1:0]     extra;

    assign instr_idx = instr_addr_i[AW+1:2];
    assign data_idx  = data_addr_i[AW+1:2];

`ifdef RISCY_MEM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end

    assign extra = lfsr_q[1:0];
`else
    assign extra = 2'b00;
`endif

    riscy_mem_channel #(.GNT_LATENCY(GNT_LATENCY)) u_instr_chan (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (instr_req_i),
        .extra_i  (extra),
        .gnt_o    (instr_gnt_o),
        .rvalid_o (instr_rvalid_o)
    );

    riscy_mem_channel #(.GNT_LATENCY(GNT_LATENCY)) u_data_chan (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (data_req_i),
        .extra_i  (extra),
        .gnt_o    (data_gnt_o),
        .rvalid_o (data_rvalid_o)
    );

    // Later non-blocking write wins, so the init port overrides a same-word store.
    always_ff @(posedge clk_i) begin
        if (data_gnt_o && data_we_i)
            mem_q[data_idx] <= apply_be(mem_q[data_idx], data_wdata_i, data_be_i);
        if (init_we_i)
            mem_q[init_addr_i] <= init_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            if (instr_gnt_o) instr_rdata_q <= mem_q[instr_idx];
            if (data_gnt_o)  data_rdata_q  <= data_we_i ? '0 : mem_q[data_idx];
        end
    end

    assign instr_rdata_o = instr_rdata_q;
    assign data_rdata_o  = data_rdata_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[31:AW+2], instr_addr_i[1:0],
                                data_addr_i[31:AW+2], data_addr_i[1:0]};

endmodule

// File: tb/tb_riscy_mem_responder.sv
// Scoreboard bench: zero-latency instance for data paths, latency-3 instance for timing.
module tb_riscy_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, init_we;
    logic [31:0] i_addr, d_addr, d_wdata, init_wdata;
    logic [3:0]  d_be;
    logic [9:0]  init_addr;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;

    logic        d3_req;
    logic [31:0] d3_addr;
    logic        d3_gnt, d3_rvalid, i3_gnt, i3_rvalid;
    logic [31:0] d3_rdata, i3_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] q_i0[$], q_d0[$], q_d3[$];

    always #5 clk = ~clk;

    riscy_mem_responder #(.MEM_WORDS(1024), .GNT_LATENCY(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(i_req), .instr_addr_i(i_addr), .instr_gnt_o(i_gnt),
        .instr_rvalid_o(i_rvalid), .instr_rdata_o(i_rdata),
        .data_req_i(d_req), .data_we_i(d_we), .data_be_i(d_be), .data_addr_i(d_addr),
        .data_wdata_i(d_wdata), .data_gnt_o(d_gnt), .data_rvalid_o(d_rvalid),
        .data_rdata_o(d_rdata),
        .init_we_i(init_we), .init_addr_i(init_addr), .init_wdata_i(init_wdata)
    );

    riscy_mem_responder #(.MEM_WORDS(1024), .GNT_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(1'b0), .instr_addr_i(32'h0), .instr_gnt_o(i3_gnt),
        .instr_rvalid_o(i3_rvalid), .instr_rdata_o(i3_rdata),
        .data_req_i(d3_req), .data_we_i(1'b0), .data_be_i(4'hF), .data_addr_i(d3_addr),
        .data_wdata_i(32'h0), .data_gnt_o(d3_gnt), .data_rvalid_o(d3_rvalid),
        .data_rdata_o(d3_rdata),
        .init_we_i(1'b0), .init_addr_i(10'h0), .init_wdata_i(32'h0)
    );

    // Scoreboard: every rvalid must match the oldest expectation pushed at its gnt.
    always @(negedge clk) begin
        logic [31:0] e;
        if (i_rvalid) begin
            checks++;
            if (q_i0.size() == 0) begin
                errors++; $display("FAIL i0_unexpected_rvalid rdata=%h", i_rdata);
            end else begin
                e = q_i0.pop_front();
                if (i_rdata !== e) begin errors++; $display("FAIL i0_rdata got=%h exp=%h", i_rdata, e); end
            end
        end
        if (d_rvalid) begin
            checks++;
            if (q_d0.size() == 0) begin
                errors++; $display("FAIL d0_unexpected_rvalid rdata=%h", d_rdata);
            end else begin
                e = q_d0.pop_front();
                if (d_rdata !== e) begin errors++; $display("FAIL d0_rdata got=%h exp=%h", d_rdata, e); end
            end
        end
        if (d3_rvalid) begin
            checks++;
            if (q_d3.size() == 0) begin
                errors++; $display("FAIL d3_unexpected_rvalid rdata=%h", d3_rdata);
            end else begin
                e = q_d3.pop_front();
                if (d3_rdata !== e) begin errors++; $display("FAIL d3_rdata got=%h exp=%h", d3_rdata, e); end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 4'hF; d_addr = 0; d_wdata = 0;
        init_we = 0; init_addr = 0; init_wdata = 0; d3_req = 0; d3_addr = 0;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({i_gnt, i_rvalid, d_gnt, d_rvalid, d3_gnt, d3_rvalid} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000000",
                               {i_gnt, i_rvalid, d_gnt, d_rvalid, d3_gnt, d3_rvalid});
        end
        checks++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got=%h/%h exp=0", i_rdata, d_rdata);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fetch_basic();
        i_req = 1; i_addr = 32'h0;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt_same_cycle got=%b exp=1", i_gnt); end
        q_i0.push_back(32'h0000_0013);
        tick();
        i_req = 0;
        @(negedge clk);
        checks++;
        if (i_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid got=%b exp=1", i_rvalid); end
        tick();
    endtask

    task automatic test_init_load();
        init_we = 1; init_addr = 10'd4; init_wdata = 32'hDEAD_BEEF;
        tick();
        init_we = 0;
        d_req = 1; d_we = 0; d_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL load_gnt got=%b exp=1", d_gnt); end
        q_d0.push_back(32'hDEAD_BEEF);
        tick();
        d_req = 0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1) begin errors++; $display("FAIL load_rvalid got=%b exp=1", d_rvalid); end
        tick();
    endtask

    task automatic test_back_to_back();
        // store with byte mask, then load granted in the store's rvalid cycle
        d_req = 1; d_we = 1; d_be = 4'b0101; d_addr = 32'h10; d_wdata = 32'h1122_3344;
        @(negedge clk);
        q_d0.push_back(32'h0);
        tick();
        d_we = 0; d_be = 4'hF;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || d_rvalid !== 1'b1) begin
            errors++; $display("FAIL b2b_gnt_rvalid got=%b%b exp=11", d_gnt, d_rvalid);
        end
        q_d0.push_back(32'hDE22_BE44);
        tick();
        d_req = 0;
        // two back-to-back fetches: word 0 then word 4
        i_req = 1; i_addr = 32'h0;
        @(negedge clk);
        q_i0.push_back(32'h0000_0013);
        tick();
        i_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin errors++; $display("FAIL b2b_fetch_gnt got=%b exp=1", i_gnt); end
        q_i0.push_back(32'hDE22_BE44);
        tick();
        i_req = 0;
        tick();
    endtask

    task automatic test_collision();
        init_we = 1; init_addr = 10'd8; init_wdata = 32'h0;
        tick();
        init_we = 0;
        i_req = 1; i_addr = 32'h20;
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h20; d_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b1) begin
            errors++; $display("FAIL collide_gnt got=%b%b exp=11", i_gnt, d_gnt);
        end
        q_i0.push_back(32'h0);
        q_d0.push_back(32'h0);
        tick();
        i_req = 0; d_req = 0; d_we = 0;
        tick();
        i_req = 1; i_addr = 32'h20;
        @(negedge clk);
        q_i0.push_back(32'hFFFF_FFFF);
        tick();
        i_req = 0;
        tick();
        // init write and store to the same word: init value must remain
        init_we = 1; init_addr = 10'd5; init_wdata = 32'hA5A5_5A5A;
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h14; d_wdata = 32'h0;
        @(negedge clk);
        q_d0.push_back(32'h0);
        tick();
        init_we = 0; d_we = 0;
        @(negedge clk);
        q_d0.push_back(32'hA5A5_5A5A);
        tick();
        d_req = 0;
        tick();
    endtask

    task automatic test_alias();
        d_req = 1; d_we = 0; d_addr = 32'h1000;
        @(negedge clk);
        q_d0.push_back(32'h0000_0013);
        tick();
        d_we = 1; d_addr = 32'h100C; d_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        q_d0.push_back(32'h0);
        tick();
        d_req = 0; d_we = 0;
        i_req = 1; i_addr = 32'hC;
        @(negedge clk);
        q_i0.push_back(32'h0BAD_F00D);
        tick();
        i_req = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 0; d_addr = 32'h10;
        @(negedge clk);
        q_d0.push_back(32'hDE22_BE44);
        tick();
        rst = 1;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt_gated got=%b exp=0", d_gnt); end
        tick();
        rst = 0; d_req = 0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_drop_rvalid got=%b/%h exp=0/0", d_rvalid, d_rdata);
        end
        tick();
        d_req = 1; d_addr = 32'h10;
        @(negedge clk);
        q_d0.push_back(32'hDE22_BE44);
        tick();
        d_req = 0;
        tick();
    endtask

    task automatic test_latency();
        d3_req = 1; d3_addr = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (d3_gnt !== (k == 3)) begin
                errors++; $display("FAIL lat3_gnt cycle=%0d got=%b exp=%b", k, d3_gnt, (k == 3));
            end
            if (k == 3) q_d3.push_back(32'h0000_0013);
            tick();
        end
        d3_req = 0;
        tick();
        d3_req = 1;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) d3_req = 0;
            @(negedge clk);
            checks++;
            if (d3_gnt !== 1'b0) begin errors++; $display("FAIL lat3_drop_gnt cycle=%0d got=%b exp=0", k, d3_gnt); end
            tick();
        end
        d3_req = 1; d3_addr = 32'h4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (d3_gnt !== (k == 3)) begin
                errors++; $display("FAIL lat3_regrant cycle=%0d got=%b exp=%b", k, d3_gnt, (k == 3));
            end
            if (k == 3) q_d3.push_back(32'h0000_0013);
            tick();
        end
        d3_req = 0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_init_load();
        test_back_to_back();
        test_collision();
        test_alias();
        test_reset_mid();
        test_latency();
        tick(); tick();
        checks++;
        if (q_i0.size() + q_d0.size() + q_d3.size() != 0) begin
            errors++; $display("FAIL missing_rvalid pending=%0d/%0d/%0d exp=0/0/0",
                               q_i0.size(), q_d0.size(), q_d3.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
